// File: rtl/gmii_tx_scheduler_pkg.sv
// Shared state encoding and preamble constants for the GMII transmit scheduler.
// Preamble insertion is enabled by GMII_TX_SCHEDULER_PREAMBLE_EN.
package gmii_tx_scheduler_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_PRE   = 3'd1;
    localparam state_t S_DATA  = 3'd2;
    localparam state_t S_DRAIN = 3'd3;
    localparam state_t S_IFG   = 3'd4;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;
    localparam int         PREAMBLE_LEN  = 7;

endpackage

// File: rtl/gmii_tx_scheduler_rr_pick.sv
// Combinational round-robin picker: first requesting index at or after ptr,
// wrapping around the request vector.
module gmii_tx_scheduler_rr_pick #(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            valid,
    output logic [IW-1:0]   idx
);

    int j;

    always_comb begin
        valid = |req;
        idx   = '0;
        j     = 0;
        // Walk offsets high to low so the nearest requester wins last
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % NREQ;
            if (req[j]) idx = IW'(j);
        end
    end

endmodule

// File: rtl/gmii_tx_scheduler.sv
// Round-robin GMII transmit scheduler with IFG enforcement and underrun abort.
// Optional preamble/SFD insertion: define GMII_TX_SCHEDULER_PREAMBLE_EN.
module gmii_tx_scheduler
    import gmii_tx_scheduler_pkg::*;
#(
    parameter  int NREQ      = 2,
    parameter  int IFG_BYTES = 12,
    parameter  int CNT_W     = 16,
    localparam int GW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              link_up,
    input  logic              isolate,
    input  logic [NREQ*8-1:0] s_tdata,
    input  logic [NREQ-1:0]   s_tvalid,
    input  logic [NREQ-1:0]   s_tlast,
    output logic [NREQ-1:0]   s_tready,
    output logic [7:0]        gmii_txd,
    output logic              gmii_tx_en,
    output logic              gmii_tx_er,
    output logic              busy,
    output logic [GW-1:0]     grant,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic [CNT_W-1:0]  underrun_cnt
);

    localparam int IFW = $clog2(IFG_BYTES + 1);

    state_t          state;
    logic [GW-1:0]   ptr;
    logic [GW-1:0]   pick_idx;
    logic            pick_valid;
    logic [IFW-1:0]  ifg_cnt;
    logic [7:0]      cur_byte;
    logic            cur_valid;
    logic            cur_last;
    logic [NREQ-1:0] gmask;
    logic            link_ok;
`ifdef GMII_TX_SCHEDULER_PREAMBLE_EN
    logic [2:0]      pre_cnt;
`endif

    gmii_tx_scheduler_rr_pick #(
        .NREQ (NREQ),
        .IW   (GW)
    ) u_rr_pick (
        .req   (s_tvalid),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        cur_byte  = '0;
        cur_valid = 1'b0;
        cur_last  = 1'b0;
        gmask     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant == GW'(i)) begin
                cur_byte  = s_tdata[i*8 +: 8];
                cur_valid = s_tvalid[i];
                cur_last  = s_tlast[i];
                gmask[i]  = 1'b1;
            end
        end
    end

    assign link_ok  = link_up & ~isolate;
    assign busy     = (state != S_IDLE);
    assign s_tready = (state == S_DATA || state == S_DRAIN) ? gmask : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            ptr          <= '0;
            grant        <= '0;
            ifg_cnt      <= '0;
            frame_cnt    <= '0;
            underrun_cnt <= '0;
            gmii_txd     <= '0;
            gmii_tx_en   <= 1'b0;
            gmii_tx_er   <= 1'b0;
`ifdef GMII_TX_SCHEDULER_PREAMBLE_EN
            pre_cnt      <= '0;
`endif
        end else begin
            gmii_txd   <= '0;
            gmii_tx_en <= 1'b0;
            gmii_tx_er <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (link_ok && pick_valid) begin
                        grant <= pick_idx;
                        ptr   <= (pick_idx == GW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
`ifdef GMII_TX_SCHEDULER_PREAMBLE_EN
                        pre_cnt <= '0;
                        state   <= S_PRE;
`else
                        state   <= S_DATA;
`endif
                    end
                end
`ifdef GMII_TX_SCHEDULER_PREAMBLE_EN
                S_PRE: begin
                    gmii_tx_en <= 1'b1;
                    pre_cnt    <= pre_cnt + 1'b1;
                    if (pre_cnt == 3'(PREAMBLE_LEN)) begin
                        gmii_txd <= SFD_BYTE;
                        state    <= S_DATA;
                    end else begin
                        gmii_txd <= PREAMBLE_BYTE;
                    end
                end
`endif
                S_DATA: begin
                    gmii_tx_en <= 1'b1;
                    if (cur_valid) begin
                        gmii_txd <= cur_byte;
                        if (cur_last) begin
                            frame_cnt <= frame_cnt + 1'b1;
                            ifg_cnt   <= '0;
                            state     <= S_IFG;
                        end
                    end else begin
                        // Source starved mid-frame: poison the frame on the wire
                        gmii_tx_er <= 1'b1;
                        if (underrun_cnt != '1) underrun_cnt <= underrun_cnt + 1'b1;
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (cur_valid && cur_last) begin
                        ifg_cnt <= '0;
                        state   <= S_IFG;
                    end
                end
                S_IFG: begin
                    if (ifg_cnt == IFW'(IFG_BYTES - 1)) state <= S_IDLE;
                    else ifg_cnt <= ifg_cnt + 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gmii_tx_scheduler.sv
// Directed testbench for gmii_tx_scheduler (NREQ=2, IFG_BYTES=12).
// Works with or without GMII_TX_SCHEDULER_PREAMBLE_EN defined.
module tb_gmii_tx_scheduler;

`ifdef GMII_TX_SCHEDULER_PREAMBLE_EN
    localparam int PRE_LEN = 8;
    localparam logic [7:0] FIRST_WIRE_BYTE = 8'h55;
`else
    localparam int PRE_LEN = 0;
    localparam logic [7:0] FIRST_WIRE_BYTE = 8'h80;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        link_up = 1'b1;
    logic        isolate = 1'b0;
    logic [15:0] s_tdata;
    logic [1:0]  s_tvalid;
    logic [1:0]  s_tlast;
    logic [1:0]  s_tready;
    logic [7:0]  gmii_txd;
    logic        gmii_tx_en;
    logic        gmii_tx_er;
    logic        busy;
    logic [0:0]  grant;
    logic [15:0] frame_cnt;
    logic [15:0] underrun_cnt;

    gmii_tx_scheduler #(
        .NREQ      (2),
        .IFG_BYTES (12),
        .CNT_W     (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .link_up      (link_up),
        .isolate      (isolate),
        .s_tdata      (s_tdata),
        .s_tvalid     (s_tvalid),
        .s_tlast      (s_tlast),
        .s_tready     (s_tready),
        .gmii_txd     (gmii_txd),
        .gmii_tx_en   (gmii_tx_en),
        .gmii_tx_er   (gmii_tx_er),
        .busy         (busy),
        .grant        (grant),
        .frame_cnt    (frame_cnt),
        .underrun_cnt (underrun_cnt)
    );

    always #4 clk = ~clk;

    int checks = 0;
    int failures = 0;

    int src_len[2];
    int src_nfr[2];
    int src_pos[2];
    int src_drop_at[2];
    int src_hold[2];

    logic       log_en[$];
    logic       log_er[$];
    logic [7:0] log_d[$];
    int         ps[$];
    int         pl[$];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_srcs();
        for (int i = 0; i < 2; i++) begin
            s_tvalid[i] = (src_nfr[i] > 0) &&
                          !(src_pos[i] == src_drop_at[i] && src_hold[i] > 0);
            s_tdata[i*8 +: 8] = {i[0], src_pos[i][6:0]};
            s_tlast[i] = (src_pos[i] == src_len[i] - 1);
        end
    endtask

    task automatic clear_srcs();
        for (int i = 0; i < 2; i++) begin
            src_len[i] = 1;
            src_nfr[i] = 0;
            src_pos[i] = 0;
            src_drop_at[i] = -1;
            src_hold[i] = 0;
        end
        drive_srcs();
    endtask

    task automatic clear_log();
        log_en.delete();
        log_er.delete();
        log_d.delete();
    endtask

    // One clock: record wire at negedge, then advance sources after the edge
    task automatic step();
        logic [1:0] acc;
        @(negedge clk);
        acc = s_tvalid & s_tready;
        log_en.push_back(gmii_tx_en);
        log_er.push_back(gmii_tx_er);
        log_d.push_back(gmii_txd);
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (acc[i]) begin
                src_pos[i]++;
                if (src_pos[i] == src_len[i]) begin
                    src_pos[i] = 0;
                    src_nfr[i]--;
                end
            end else if (src_nfr[i] > 0 && src_pos[i] == src_drop_at[i] &&
                         src_hold[i] > 0) begin
                src_hold[i]--;
            end
        end
        drive_srcs();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic analyze();
        ps.delete();
        pl.delete();
        for (int k = 0; k < log_en.size(); k++) begin
            if (log_en[k] && (k == 0 || !log_en[k-1])) begin
                ps.push_back(k);
                pl.push_back(1);
            end else if (log_en[k]) begin
                pl[pl.size()-1] = pl[pl.size()-1] + 1;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_srcs();
        step();
        step();
        reset = 1'b0;
        clear_log();
    endtask

    initial begin
        int bad;
        int ers;
        int s;
        int fc0;

        s_tdata = '0;
        s_tvalid = '0;
        s_tlast = '0;
        clear_srcs();

        // Reset state
        do_reset();
        check("rst_tx_en", gmii_tx_en, 0);
        check("rst_tx_er", gmii_tx_er, 0);
        check("rst_txd", gmii_txd, 0);
        check("rst_busy", busy, 0);
        check("rst_grant", grant, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_underrun_cnt", underrun_cnt, 0);
        check("rst_tready", s_tready, 0);

        // Single 64-byte frame from source 0
        src_len[0] = 64;
        src_nfr[0] = 1;
        drive_srcs();
        clear_log();
        run(120);
        analyze();
        check("t2_pulses", ps.size(), 1);
        check("t2_len", pl[0], PRE_LEN + 64);
        s = ps[0];
`ifdef GMII_TX_SCHEDULER_PREAMBLE_EN
        bad = 0;
        for (int k = 0; k < 7; k++) if (log_d[s+k] !== 8'h55) bad++;
        check("t2_pre_bad", bad, 0);
        check("t2_sfd", log_d[s+7], 8'hD5);
`endif
        bad = 0;
        for (int k = 0; k < 64; k++) begin
            if (log_d[s+PRE_LEN+k] !== {1'b0, 7'(k)}) bad++;
        end
        check("t2_data_bad", bad, 0);
        ers = 0;
        foreach (log_er[k]) if (log_er[k]) ers++;
        check("t2_tx_er", ers, 0);
        check("t2_frame_cnt", frame_cnt, 1);
        check("t2_busy", busy, 0);

        // Both sources continuously valid, three 10-byte frames each
        do_reset();
        src_len[0] = 10;
        src_nfr[0] = 3;
        src_len[1] = 10;
        src_nfr[1] = 3;
        drive_srcs();
        run(300);
        analyze();
        check("t3_pulses", ps.size(), 6);
        bad = 0;
        for (int p = 0; p < 6; p++) if (pl[p] != PRE_LEN + 10) bad++;
        check("t3_len_bad", bad, 0);
        for (int p = 0; p < 6; p++) begin
            check($sformatf("t3_src%0d", p), log_d[ps[p]+PRE_LEN][7], p % 2);
        end
        for (int p = 0; p < 5; p++) begin
            check($sformatf("t3_gap%0d", p), ps[p+1] - (ps[p] + pl[p]), 13);
        end
        check("t3_frame_cnt", frame_cnt, 6);

        // Link down holds off source 1, then release
        link_up = 1'b0;
        src_len[1] = 8;
        src_nfr[1] = 1;
        drive_srcs();
        clear_log();
        run(20);
        analyze();
        check("t4_no_tx", ps.size(), 0);
        check("t4_tready", s_tready, 0);
        check("t4_busy", busy, 0);
        link_up = 1'b1;
        clear_log();
        run(40);
        analyze();
        check("t4_pulses", ps.size(), 1);
        check("t4_start", ps[0], 2);
        check("t4_first_byte", log_d[2], FIRST_WIRE_BYTE);
        check("t4_frame_cnt", frame_cnt, 7);

        // Underrun after byte 20 of 40
        fc0 = int'(frame_cnt);
        src_len[0] = 40;
        src_nfr[0] = 1;
        src_drop_at[0] = 20;
        src_hold[0] = 1;
        drive_srcs();
        clear_log();
        run(100);
        analyze();
        check("t5_pulses", ps.size(), 1);
        check("t5_len", pl[0], PRE_LEN + 21);
        check("t5_er_last", log_er[ps[0]+pl[0]-1], 1);
        check("t5_txd_last", log_d[ps[0]+pl[0]-1], 0);
        ers = 0;
        foreach (log_er[k]) if (log_er[k]) ers++;
        check("t5_er_count", ers, 1);
        check("t5_drained", src_nfr[0], 0);
        check("t5_underrun_cnt", underrun_cnt, 1);
        check("t5_frame_cnt", frame_cnt, fc0);
        check("t5_busy", busy, 0);
        src_drop_at[0] = -1;

        // Reset during byte 30 of a frame from source 1
        src_len[1] = 60;
        src_nfr[1] = 1;
        drive_srcs();
        for (int k = 0; k < 200 && src_pos[1] != 30; k++) step();
        check("t6_reach", src_pos[1], 30);
        check("t6_grant_pre", grant, 1);
        reset = 1'b1;
        step();
        check("t6_tx_en", gmii_tx_en, 0);
        check("t6_busy", busy, 0);
        check("t6_grant", grant, 0);
        check("t6_frame_cnt", frame_cnt, 0);
        check("t6_underrun_cnt", underrun_cnt, 0);
        do_reset();

        // Isolate mid-frame: current frame completes, next held off
        src_len[0] = 20;
        src_nfr[0] = 1;
        src_len[1] = 10;
        src_nfr[1] = 1;
        drive_srcs();
        for (int k = 0; k < 100 && src_pos[0] != 5; k++) step();
        check("t7_reach", src_pos[0], 5);
        isolate = 1'b1;
        run(80);
        check("t7_frame_cnt_a", frame_cnt, 1);
        check("t7_src1_held", src_nfr[1], 1);
        check("t7_busy", busy, 0);
        check("t7_tready", s_tready, 0);
        isolate = 1'b0;
        clear_log();
        run(60);
        analyze();
        check("t7_pulses", ps.size(), 1);
        check("t7_frame_cnt_b", frame_cnt, 2);
        check("t7_src1_done", src_nfr[1], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gmii_tx_scheduler.md
Name: gmii_tx_scheduler

Overview:
- Shares the GMII transmit side of the SGMII PCS/PMA core between NREQ byte-stream frame sources.
- Round-robin arbitration at frame boundaries; optional preamble/SFD insertion; enforces inter-frame gap (IFG).
- Gates new frames on link status and PCS isolate; handles source underrun.
- Runs in the 125 MHz GMII tx_clk domain, directly in front of the gmii tx_en/tx_er/txd pins of the PCS/PMA core.

Parameters:
- NREQ, 2: number of requesting sources (1..8).
- IFG_BYTES, 12: idle cycles forced between frames (>=1).
- CNT_W, 16: width of the frame and underrun statistics counters.

Ports:
- clk  in  1  GMII tx clock, 125 MHz.
- reset  in  1  synchronous, active-high.
- link_up  in  1  PCS status_vector[0].
- isolate  in  1  PCS gmii_isolate.
- s_tdata  in  NREQ*8  per-source byte; source i uses bits [8i+7:8i].
- s_tvalid  in  NREQ  per-source byte valid.
- s_tlast  in  NREQ  per-source last byte of frame.
- s_tready  out  NREQ  per-source byte accepted; combinational from state/grant only.
- gmii_txd  out  8  to PCS.
- gmii_tx_en  out  1  to PCS.
- gmii_tx_er  out  1  to PCS.
- busy  out  1  state != IDLE.
- grant  out  max(1,$clog2(NREQ))  index of current/last granted source.
- frame_cnt  out  CNT_W  completed frames, wrapping.
- underrun_cnt  out  CNT_W  aborted frames, saturating.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values:
  - gmii_txd=0, gmii_tx_en=0, gmii_tx_er=0, busy=0, grant=0, counters=0.
  - RR pointer=0, state=IDLE.
  - Reset mid-frame drops tx_en on the next edge; no completion and no counter update.
- GMII outputs are registered: a byte accepted on cycle t appears on gmii_txd/gmii_tx_en at t+1.
- States: IDLE, PRE, DATA, DRAIN, IFG.
- IDLE:
  - If link_up && !isolate and any s_tvalid, pick the first valid index at or after ptr, cyclically.
  - Set grant, ptr=grant+1 mod NREQ, go to PRE (or DATA if the feature is absent).
  - Outputs idle: tx_en=0, txd=0.
- PRE: emit the preamble sequence (see Optional Feature), then go to DATA. s_tready=0.
- DATA:
  - s_tready[grant]=1; all other s_tready bits stay 0.
  - On valid: emit tx_en=1, txd=byte. If s_tlast, frame_cnt++ and go to IFG.
  - If s_tvalid[grant]=0 (underrun): emit tx_en=1, tx_er=1, txd=0 for one cycle, then underrun_cnt++ (saturating) and go to DRAIN.
- DRAIN:
  - tx_en=0; s_tready[grant]=1.
  - Discard bytes until a valid && last byte is accepted, then go to IFG.
- IFG:
  - tx_en=0; count IFG_BYTES cycles starting at the cycle after the last tx_en=1 output, then go to IDLE.
  - Arbitration is evaluated in IDLE, so the minimum gap between frames is IFG_BYTES+1 idle cycles on the wire.
- link_up/isolate are sampled only in IDLE; a frame in progress always completes (or drains).
- A source whose s_tvalid rises during another frame waits; round-robin guarantees service within NREQ frames.
- Simultaneous tlast and a new request from another source: the new source is granted only after IFG.
- NREQ=1: grant is constant 0 and the pointer logic is degenerate.

Optional Feature:
- Macro: GMII_TX_SCHEDULER_PREAMBLE_EN.
- Defined: PRE state emits 7 cycles of 8'h55, then 1 cycle of 8'hD5, all with tx_en=1; the first source byte appears 8 cycles after the grant cycle +1. Sources supply frames starting at the destination address.
- Undefined: PRE state is not generated; IDLE goes directly to DATA, and sources supply their own preamble/SFD. The first byte is accepted the cycle after the grant.

Decomposition:
- Package gmii_tx_scheduler_pkg holds:
  - state enum (IDLE, PRE, DATA, DRAIN, IFG).
  - constants PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5, PREAMBLE_LEN=7.
- One sub-module, rr_pick:
  - Combinational.
  - Inputs: request vector, pointer.
  - Outputs: valid, index.
  - Instantiated once.

Test Plan:
- Preamble on, NREQ=2, source0 sends a 64-byte frame with link_up=1 -> 7x55, D5, 64 bytes with tx_en contiguous; frame_cnt=1; tx_er never asserted.
- Both sources continuously valid, three 10-byte frames each -> grants alternate 0,1,0,1,0,1; each gap between tx_en pulses is exactly 13 cycles.
- link_up=0 while source1 is valid -> no tx_en and s_tready=0; raise link_up -> frame starts, first preamble byte 2 cycles later.
- Source0 drops s_tvalid after byte 20 of 40 -> one cycle tx_en=1/tx_er=1/txd=0, then tx_en=0; the remaining 20 bytes are drained; underrun_cnt=1; frame_cnt unchanged.
- Assert reset during byte 30 of a frame -> next cycle tx_en=0, busy=0, grant=0; counters are 0.
- isolate rises mid-frame -> the frame completes; the next frame is not granted until isolate=0.
